// File: rtl/mat_res_framer.sv
// Buffers one result matrix from the engine's byte stream and replays it as a framed packet:
// HDR, LEN, data bytes, CSUM (LAST on CSUM). Collect and send never overlap.
module mat_res_framer #(
  parameter int         DEPTH = 16,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_e,
  input  logic [7:0] s_axis_data,
  input  logic       s_axis_valid,
  output logic       s_axis_ready,
  input  logic       s_axis_last,
  output logic [7:0] m_axis_data,
  output logic       m_axis_valid,
  input  logic       m_axis_ready,
  output logic       m_axis_last,
  output logic       o_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    COLLECT,
    SEND_HDR,
    SEND_LEN,
    SEND_DATA,
    SEND_CSUM
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [7:0]    csum_reg;
  logic          overflow_reg;
  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          last_reg;

  logic [7:0]    frame_mem [DEPTH];

  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] count_inc;
  logic [PW-1:0] rd_ptr_inc;
  logic [7:0]    count_byte;
  logic          frame_full;
  logic          frame_close;
  logic          data_done;

  assign s_axis_ready = i_rst_n && (state_reg == COLLECT);
  assign m_axis_data  = data_reg;
  assign m_axis_valid = valid_reg;
  assign m_axis_last  = last_reg;
  assign o_overflow   = overflow_reg;

  assign in_xfer     = i_clk_e & s_axis_valid & s_axis_ready;
  assign out_xfer    = i_clk_e & valid_reg & m_axis_ready;
  assign count_inc   = count_reg + CW'(1);
  assign rd_ptr_inc  = rd_ptr_reg + PW'(1);
  assign count_byte  = 8'(count_reg);
  assign frame_full  = (count_inc == CW'(DEPTH));
  assign frame_close = s_axis_last | frame_full;
  // rd_ptr never exceeds count-1, so the widened compare is exact.
  assign data_done   = ({1'b0, rd_ptr_reg} == (count_reg - CW'(1)));

  // Count is always below DEPTH while collecting, so the low bits address the buffer.
  always_ff @(posedge i_clk) begin
    if (in_xfer) begin
      frame_mem[count_reg[PW-1:0]] <= s_axis_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= COLLECT;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      csum_reg     <= '0;
      overflow_reg <= 1'b0;
      data_reg     <= 8'h00;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
    end else if (i_clk_e) begin
      case (state_reg)
        COLLECT: begin
          if (in_xfer) begin
            count_reg <= count_inc;
            csum_reg  <= csum_reg + s_axis_data;
            if (frame_close) begin
              state_reg <= SEND_HDR;
              valid_reg <= 1'b1;
              data_reg  <= HDR;
              last_reg  <= 1'b0;
              if (frame_full && !s_axis_last) begin
                overflow_reg <= 1'b1;
              end
            end
          end
        end
        SEND_HDR: begin
          if (out_xfer) begin
            state_reg <= SEND_LEN;
            data_reg  <= count_byte;
          end
        end
        SEND_LEN: begin
          if (out_xfer) begin
            state_reg  <= SEND_DATA;
            rd_ptr_reg <= '0;
            data_reg   <= frame_mem[0];
          end
        end
        SEND_DATA: begin
          if (out_xfer) begin
            if (data_done) begin
              state_reg <= SEND_CSUM;
              data_reg  <= count_byte + csum_reg;
              last_reg  <= 1'b1;
            end else begin
              rd_ptr_reg <= rd_ptr_inc;
              data_reg   <= frame_mem[rd_ptr_inc];
            end
          end
        end
        SEND_CSUM: begin
          if (out_xfer) begin
            state_reg <= COLLECT;
            count_reg <= '0;
            csum_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            data_reg  <= 8'h00;
          end
        end
        default: begin
          state_reg <= COLLECT;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_res_framer.sv
// Random and directed stimulus for mat_res_framer, checked against a frame-level model
// built from input bytes (HDR, LEN, payload, LEN+sum) and a per-cycle busy/ready expectation.
module tb_mat_res_framer;

  localparam int         DEPTH = 16;
  localparam logic [7:0] HDR   = 8'hA5;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_clk_e = 1'b0;
  logic [7:0] s_axis_data = 8'h00;
  logic       s_axis_valid = 1'b0;
  logic       s_axis_ready;
  logic       s_axis_last = 1'b0;
  logic [7:0] m_axis_data;
  logic       m_axis_valid;
  logic       m_axis_ready = 1'b0;
  logic       m_axis_last;
  logic       o_overflow;

  mat_res_framer #(.DEPTH(DEPTH), .HDR(HDR)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clk_e      (i_clk_e),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] stim_q [$];   // {last, data} input beats still to offer
  logic [8:0] exp_q  [$];   // {last, data} output beats still owed
  logic [7:0] cur_q  [$];   // payload of the frame being collected
  bit         model_ovf = 1'b0;
  int         mode = 0;     // 0: always go, 1: alternating enable/ready, 2: random
  int         cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void close_frame();
    int sum;
    sum = cur_q.size();
    exp_q.push_back({1'b0, HDR});
    exp_q.push_back({1'b0, 8'(cur_q.size())});
    foreach (cur_q[i]) begin
      exp_q.push_back({1'b0, cur_q[i]});
      sum += cur_q[i];
    end
    exp_q.push_back({1'b1, 8'(sum % 256)});
    cur_q.delete();
  endfunction

  function automatic void model_in(input logic [7:0] b, input logic l);
    cur_q.push_back(b);
    if (l || cur_q.size() == DEPTH) begin
      if (!l) model_ovf = 1'b1;
      close_frame();
    end
  endfunction

  function automatic void push_frame(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      stim_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'((base + i) % 256)});
    end
  endfunction

  task automatic cycle();
    bit busy;
    bit in_x;
    bit out_x;
    @(negedge i_clk);
    busy = (exp_q.size() != 0);
    chk("s_ready", {31'd0, s_axis_ready}, {31'd0, !busy});
    chk("m_valid", {31'd0, m_axis_valid}, {31'd0, busy});
    chk("overflow", {31'd0, o_overflow}, {31'd0, model_ovf});
    if (busy) begin
      chk("m_data", {24'd0, m_axis_data}, {24'd0, exp_q[0][7:0]});
      chk("m_last", {31'd0, m_axis_last}, {31'd0, exp_q[0][8]});
    end
    case (mode)
      0: begin i_clk_e = 1'b1; m_axis_ready = 1'b1; end
      1: begin i_clk_e = ((cyc / 2) % 2) == 1; m_axis_ready = (cyc % 2) == 1; end
      default: begin i_clk_e = $urandom_range(0, 3) != 0; m_axis_ready = $urandom_range(0, 2) != 0; end
    endcase
    if (stim_q.size() != 0) begin
      s_axis_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_data  = stim_q[0][7:0];
      s_axis_last  = stim_q[0][8];
    end else begin
      s_axis_valid = 1'b0;
      s_axis_data  = 8'($urandom);
      s_axis_last  = 1'($urandom);
    end
    #1;
    out_x = i_clk_e && m_axis_ready && busy;
    in_x  = i_clk_e && s_axis_valid && !busy;
    if (out_x) begin
      $display("beat %0d: data=%02h last=%0d", cyc, exp_q[0][7:0], exp_q[0][8]);
      void'(exp_q.pop_front());
    end
    if (in_x) begin
      model_in(stim_q[0][7:0], stim_q[0][8]);
      void'(stim_q.pop_front());
    end
    cyc++;
  endtask

  task automatic run_phase(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (stim_q.size() == 0 && exp_q.size() == 0) break;
      cycle();
    end
    chk({tag, "_timeout"}, stim_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_s_ready", {31'd0, s_axis_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_axis_last}, 32'd0);
    chk("rst_m_data", {24'd0, m_axis_data}, 32'd0);
    chk("rst_overflow", {31'd0, o_overflow}, 32'd0);
    i_rst_n = 1'b1;

    // Basic frame, then single byte; back-to-back stim keeps valid high during send.
    mode = 0;
    push_frame(4, 0);
    stim_q[0][7:0] = 8'h10; stim_q[1][7:0] = 8'h20; stim_q[2][7:0] = 8'h30; stim_q[3][7:0] = 8'h40;
    stim_q.push_back({1'b1, 8'hFF});
    run_phase("basic", 200);
    chk("ovf_after_basic", {31'd0, o_overflow}, 32'd0);

    // Same frame under alternating enable and ready.
    mode = 1;
    push_frame(4, 0);
    stim_q[0][7:0] = 8'h10; stim_q[1][7:0] = 8'h20; stim_q[2][7:0] = 8'h30; stim_q[3][7:0] = 8'h40;
    run_phase("stall", 400);

    // 17 bytes with LAST on the 17th: truncated frame then a one-byte frame.
    mode = 0;
    push_frame(17, 0);
    run_phase("overflow", 400);
    chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);

    // Random frames including lengths beyond DEPTH.
    mode = 2;
    for (int f = 0; f < 40; f++) begin
      push_frame($urandom_range(1, 20), $urandom_range(0, 255));
    end
    run_phase("random", 20000);

    // Reset while streaming payload bytes.
    mode = 0;
    push_frame(4, 0);
    stim_q[0][7:0] = 8'h10; stim_q[1][7:0] = 8'h20; stim_q[2][7:0] = 8'h30; stim_q[3][7:0] = 8'h40;
    for (int i = 0; i < 50 && (stim_q.size() != 0 || exp_q.size() > 5); i++) cycle();
    chk("pre_reset_in_data", exp_q.size(), 5);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, m_axis_valid}, 32'd0);
    chk("arst_m_last", {31'd0, m_axis_last}, 32'd0);
    chk("arst_m_data", {24'd0, m_axis_data}, 32'd0);
    chk("arst_s_ready", {31'd0, s_axis_ready}, 32'd0);
    chk("arst_overflow", {31'd0, o_overflow}, 32'd0);
    stim_q.delete(); exp_q.delete(); cur_q.delete();
    model_ovf = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    push_frame(4, 0);
    stim_q[0][7:0] = 8'h10; stim_q[1][7:0] = 8'h20; stim_q[2][7:0] = 8'h30; stim_q[3][7:0] = 8'h40;
    run_phase("post_reset", 200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
